// File: rtl/controle_pkg.sv
// Shared encodings for the polynomial controller and its datapath.
// CONTROLE_LINEAR_EN adds the MULB state used by the linear (B*X + C) path.
package controle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDX  = 3'd1,
        ST_MULA = 3'd2,
        ST_ADDB = 3'd3,
        ST_MULX = 3'd4,
        ST_ADDC = 3'd5,
        ST_DONE = 3'd6
`ifdef CONTROLE_LINEAR_EN
        ,
        ST_MULB = 3'd7
`endif
    } state_t;

    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       ls;
        logic       lh;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_A     = 2'b01;
    localparam logic [1:0] SEL_B     = 2'b10;
    localparam logic [1:0] SEL_C     = 2'b11;

    localparam logic [1:0] M1_OUTM0  = 2'b00;
    localparam logic [1:0] M1_REGX   = 2'b01;
    localparam logic [1:0] M1_REGS   = 2'b10;
    localparam logic [1:0] M1_REGH   = 2'b11;

    localparam logic [1:0] M2_REGX   = 2'b00;
    localparam logic [1:0] M2_OUTM0  = 2'b01;
    localparam logic [1:0] M2_REGS   = 2'b10;
    localparam logic [1:0] M2_REGH   = 2'b11;

    localparam logic       OP_ADD    = 1'b0;
    localparam logic       OP_MUL    = 1'b1;

endpackage

// File: rtl/controle_decod.sv
// Combinational state -> control-word decoder; zero latency, no backpressure.
// CONTROLE_LINEAR_EN adds the MULB decode.
module controle_decod
    import controle_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_LDX: begin
                ctrl_o.lx   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
            ST_MULA: begin
                ctrl_o.m0   = SEL_A;
                ctrl_o.m1   = M1_OUTM0;
                ctrl_o.m2   = M2_REGX;
                ctrl_o.h    = OP_MUL;
                ctrl_o.lh   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
            ST_ADDB: begin
                ctrl_o.m0   = SEL_B;
                ctrl_o.m1   = M1_OUTM0;
                ctrl_o.m2   = M2_REGH;
                ctrl_o.h    = OP_ADD;
                ctrl_o.ls   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
            ST_MULX: begin
                ctrl_o.m0   = SEL_ZERO;
                ctrl_o.m1   = M1_REGS;
                ctrl_o.m2   = M2_REGX;
                ctrl_o.h    = OP_MUL;
                ctrl_o.lh   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
            ST_ADDC: begin
                ctrl_o.m0   = SEL_C;
                ctrl_o.m1   = M1_OUTM0;
                ctrl_o.m2   = M2_REGH;
                ctrl_o.h    = OP_ADD;
                ctrl_o.ls   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
`ifdef CONTROLE_LINEAR_EN
            ST_MULB: begin
                ctrl_o.m0   = SEL_B;
                ctrl_o.m1   = M1_OUTM0;
                ctrl_o.m2   = M2_REGX;
                ctrl_o.h    = OP_MUL;
                ctrl_o.lh   = 1'b1;
                ctrl_o.busy = 1'b1;
            end
`endif
            ST_DONE: ctrl_o.done = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/controle.sv
// Moore sequencer for Resultado = A*X^2 + B*X + C (Horner); done 6 cycles after start.
// start/done four-phase handshake; CONTROLE_LINEAR_EN adds the linear B*X + C path.
module controle
    import controle_pkg::*;
(
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
`ifdef CONTROLE_LINEAR_EN
    input  logic       linear,
`endif
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       busy,
    output logic       done
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

`ifdef CONTROLE_LINEAR_EN
    logic lin_q, lin_d;

    // Path choice is latched with the accepted start so linear need not be held.
    always_comb begin
        lin_d = lin_q;
        if (state_q == ST_IDLE && start) begin
            lin_d = linear;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            lin_q <= 1'b0;
        end else begin
            lin_q <= lin_d;
        end
    end
`endif

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_LDX : ST_IDLE;
`ifdef CONTROLE_LINEAR_EN
            ST_LDX:  state_d = lin_q ? ST_MULB : ST_MULA;
            ST_MULB: state_d = ST_ADDC;
`else
            ST_LDX:  state_d = ST_MULA;
`endif
            ST_MULA: state_d = ST_ADDB;
            ST_ADDB: state_d = ST_MULX;
            ST_MULX: state_d = ST_ADDC;
            ST_ADDC: state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    controle_decod u_decod (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign lx   = ctrl.lx;
    assign m0   = ctrl.m0;
    assign m1   = ctrl.m1;
    assign m2   = ctrl.m2;
    assign h    = ctrl.h;
    assign ls   = ctrl.ls;
    assign lh   = ctrl.lh;
    assign busy = ctrl.busy;
    assign done = ctrl.done;

endmodule

// File: tb/tb_controle.sv
// Bench for controle: a behavioural datapath follows the control lines and a scoreboard
// holds the expected Resultado of each run; CONTROLE_LINEAR_EN enables the linear test.
module tb_controle;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
`ifdef CONTROLE_LINEAR_EN
    logic        linear = 1'b0;
`endif
    logic        lx, h, ls, lh, busy, done;
    logic [1:0]  m0, m1, m2;
    logic [11:0] cw;

    logic [15:0] nx = '0, ra = '0, rb = '0, rc = '0;
    logic [15:0] regx = '0, regs = '0, regh = '0;
    logic [15:0] outm0, op1, op2, ula;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] sb[$];

    always #5 ck = ~ck;

    controle dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
`ifdef CONTROLE_LINEAR_EN
        .linear(linear),
`endif
        .lx    (lx),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .h     (h),
        .ls    (ls),
        .lh    (lh),
        .busy  (busy),
        .done  (done)
    );

    assign cw = {lx, m0, m1, m2, h, ls, lh, busy, done};

    // Datapath plant steered only by the DUT control lines.
    always_comb begin
        case (m0)
            2'b00:   outm0 = 16'd0;
            2'b01:   outm0 = ra;
            2'b10:   outm0 = rb;
            default: outm0 = rc;
        endcase
        case (m1)
            2'b00:   op1 = outm0;
            2'b01:   op1 = regx;
            2'b10:   op1 = regs;
            default: op1 = regh;
        endcase
        case (m2)
            2'b00:   op2 = regx;
            2'b01:   op2 = outm0;
            2'b10:   op2 = regs;
            default: op2 = regh;
        endcase
        ula = h ? 16'(op1 * op2) : 16'(op1 + op2);
    end

    always_ff @(posedge ck) begin
        if (lx) regx <= nx;
        if (ls) regs <= ula;
        if (lh) regh <= ula;
    end

    function automatic logic [15:0] poly(input logic [15:0] a, b, c, x, input bit lin);
        longint unsigned r;
        if (lin) r = longint'(b) * x + c;
        else     r = longint'(a) * x * x + longint'(b) * x + c;
        return r[15:0];
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 (state LDX).
    task automatic kick(input logic [15:0] x, a, b, c, input bit lin, input bit hold);
        nx = x; ra = a; rb = b; rc = c;
`ifdef CONTROLE_LINEAR_EN
        linear = lin;
`endif
        start = 1'b1;
        sb.push_back(poly(a, b, c, x, lin));
        @(negedge ck);
        if (!hold) start = 1'b0;
`ifdef CONTROLE_LINEAR_EN
        linear = 1'b0;
`endif
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 40) begin
            @(negedge ck);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge ck);
        n_cmp++;
        if (cw !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", cw, 12'h000);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge ck);
        n_cmp++;
        if (cw !== 12'h000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want %b", cw, 12'h000);
        end
    endtask

    task automatic test_control_word;
        logic [11:0] exp_cw [6];
        logic [15:0] exp_r;
        int          busy_n;
        exp_cw[0] = 12'b1_00_00_00_0_0_0_1_0;
        exp_cw[1] = 12'b0_01_00_00_1_0_1_1_0;
        exp_cw[2] = 12'b0_10_00_11_0_1_0_1_0;
        exp_cw[3] = 12'b0_00_10_00_1_0_1_1_0;
        exp_cw[4] = 12'b0_11_00_11_0_1_0_1_0;
        exp_cw[5] = 12'b0_00_00_00_0_0_0_0_1;
        busy_n = 0;
        kick(16'd3, 16'd2, 16'd5, 16'd7, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge ck);
            busy_n += int'(busy);
            n_cmp++;
            if (cw !== exp_cw[k-1]) begin
                n_err++;
                $display("FAIL ctrl_word_cycle%0d: got %b want %b", k, cw, exp_cw[k-1]);
            end
            if (k == 3) begin
                n_cmp++;
                if (regh !== 16'd6) begin
                    n_err++;
                    $display("FAIL h_a_times_x: got %0d want 6", regh);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (regh !== 16'd33) begin
                    n_err++;
                    $display("FAIL h_s_times_x: got %0d want 33", regh);
                end
            end
        end
        n_cmp++;
        if (busy_n != 5) begin
            n_err++;
            $display("FAIL busy_length: got %0d want 5", busy_n);
        end
        exp_r = sb.pop_front();
        n_cmp++;
        if (done !== 1'b1 || regs !== exp_r) begin
            n_err++;
            $display("FAIL quad_result: done=%b S=%0d want done=1 S=%0d", done, regs, exp_r);
        end
        @(negedge ck);
        n_cmp++;
        if (cw !== 12'h000) begin
            n_err++;
            $display("FAIL idle_after_done: got %b want %b", cw, 12'h000);
        end
    endtask

    task automatic test_wrap;
        int          cyc;
        logic [15:0] exp_r;
        kick(16'd256, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        wait_done(1, cyc);
        exp_r = sb.pop_front();
        n_cmp++;
        if (cyc != 6 || regs !== exp_r) begin
            n_err++;
            $display("FAIL wrap: cycle=%0d S=%0d want cycle=6 S=%0d", cyc, regs, exp_r);
        end
        @(negedge ck);
    endtask

    task automatic test_reset_mid;
        int          cyc, ls_n;
        logic [15:0] exp_r;
        kick(16'd3, 16'd2, 16'd5, 16'd7, 1'b0, 1'b0);
        repeat (3) @(negedge ck);
        n_cmp++;
        if (cw !== 12'b0_00_10_00_1_0_1_1_0) begin
            n_err++;
            $display("FAIL in_mulx: got %b want %b", cw, 12'b0_00_10_00_1_0_1_1_0);
        end
        rst = 1'b0;
        void'(sb.pop_front());
        @(negedge ck);
        n_cmp++;
        if (cw !== 12'h000) begin
            n_err++;
            $display("FAIL abort_outputs: got %b want %b", cw, 12'h000);
        end
        rst = 1'b1;
        ls_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ck);
            ls_n += int'(ls) + int'(done) + int'(busy);
        end
        n_cmp++;
        if (ls_n != 0) begin
            n_err++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", ls_n);
        end
        kick(16'd4, 16'd3, 16'd2, 16'd1, 1'b0, 1'b0);
        wait_done(1, cyc);
        exp_r = sb.pop_front();
        n_cmp++;
        if (cyc != 6 || regs !== exp_r) begin
            n_err++;
            $display("FAIL rerun_after_abort: cycle=%0d S=%0d want cycle=6 S=%0d", cyc, regs, exp_r);
        end
        @(negedge ck);
    endtask

    task automatic test_hold;
        int          lx_n, done_cyc;
        logic [15:0] exp_r;
        lx_n = 0;
        done_cyc = -1;
        kick(16'd5, 16'd1, 16'd1, 16'd1, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge ck);
            lx_n += int'(lx);
            if (done && done_cyc < 0) done_cyc = k;
        end
        exp_r = sb.pop_front();
        n_cmp++;
        if (lx_n != 1 || done_cyc != 6) begin
            n_err++;
            $display("FAIL hold_single_run: runs=%0d done_cycle=%0d want runs=1 done_cycle=6", lx_n, done_cyc);
        end
        n_cmp++;
        if (done !== 1'b1 || regs !== exp_r) begin
            n_err++;
            $display("FAIL hold_done_kept: done=%b S=%0d want done=1 S=%0d", done, regs, exp_r);
        end
        start = 1'b0;
        @(negedge ck);
        n_cmp++;
        if (cw !== 12'h000) begin
            n_err++;
            $display("FAIL hold_release_idle: got %b want %b", cw, 12'h000);
        end
    endtask

    task automatic test_back_to_back;
        int          cyc;
        logic [15:0] x, a, b, c, exp_r;
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom); a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
            kick(x, a, b, c, 1'b0, 1'b0);
            wait_done(1, cyc);
            exp_r = sb.pop_front();
            n_cmp++;
            if (cyc != 6 || regs !== exp_r) begin
                n_err++;
                $display("FAIL b2b_run%0d: cycle=%0d S=%0d want cycle=6 S=%0d", i, cyc, regs, exp_r);
            end
            @(negedge ck);
        end
    endtask

`ifdef CONTROLE_LINEAR_EN
    task automatic test_linear;
        int          cyc;
        logic [15:0] exp_r;
        kick(16'd10, 16'd9, 16'd4, 16'd1, 1'b1, 1'b0);
        @(negedge ck);
        n_cmp++;
        if (cw !== 12'b0_10_00_00_1_0_1_1_0) begin
            n_err++;
            $display("FAIL mulb_word: got %b want %b", cw, 12'b0_10_00_00_1_0_1_1_0);
        end
        wait_done(2, cyc);
        exp_r = sb.pop_front();
        n_cmp++;
        if (cyc != 4 || regs !== exp_r || exp_r !== 16'd41) begin
            n_err++;
            $display("FAIL linear_result: cycle=%0d S=%0d want cycle=4 S=41", cyc, regs);
        end
        @(negedge ck);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge ck);
        test_reset;
        test_control_word;
        test_wrap;
        test_reset_mid;
        test_hold;
        test_back_to_back;
`ifdef CONTROLE_LINEAR_EN
        test_linear;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
